// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
package uart_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEND = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_t;

  localparam int MAX_REQ = 16;

  // Modular increment of a requester index: n-1 wraps to 0.
  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 32'sd1 >= n) ? 32'sd0 : ptr + 32'sd1;
  endfunction

endpackage

// File: rtl/uart_send_inf.sv
// Byte-send handshake towards uart_comm: en/data held until completed pulses.
interface uart_send_inf;
  logic       en;
  logic [7:0] data;
  logic       completed;

  modport sender   (output en, output data, input completed);
  modport receiver (input en, input data, output completed);
endinterface

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of req at or above ptr, wrapping to 0.
module uart_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [IW:0]   sum;
  logic [IW-1:0] cand;
  logic          hit;

  // Walk the requesters in priority order starting at ptr; keep the first hit.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    sum   = '0;
    cand  = '0;
    hit   = 1'b0;
    for (int k = 0; k < N; k++) begin
      sum   = {1'b0, ptr} + (IW+1)'(k);
      cand  = (sum >= (IW+1)'(N)) ? IW'(sum - (IW+1)'(N)) : IW'(sum);
      hit   = ~found & req[cand];
      idx   = hit ? cand : idx;
      found = found | hit;
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin scheduler sharing one uart_comm transmitter among NUM_REQ packet streams.
// Optional watchdog on stalled owners is enabled by defining UART_TX_ARB_TIMEOUT_EN.
module uart_tx_arb
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
`ifdef UART_TX_ARB_TIMEOUT_EN
  parameter int TIMEOUT_CYC = 1000000,
`endif
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ*8-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  uart_send_inf.sender         send,
  output logic [IDX_W-1:0]     grant_idx,
`ifdef UART_TX_ARB_TIMEOUT_EN
  output logic                 timeout_err,
`endif
  output logic                 busy
);

  arb_state_t         state;
  logic [IDX_W-1:0]   rr_ptr;
  logic               lock;
  logic [NUM_REQ-1:0] owner_mask;
  logic [NUM_REQ-1:0] cand;
  logic [NUM_REQ-1:0] pick_onehot;
  logic               pick_found;
  logic [IDX_W-1:0]   pick_idx;
  logic [IDX_W-1:0]   ptr_after;
  logic               to_fire;

  // While a packet lock is held only the owner may be picked again.
  always_comb begin
    owner_mask            = '0;
    owner_mask[grant_idx] = req_valid[grant_idx];
    pick_onehot           = '0;
    pick_onehot[pick_idx] = 1'b1;
  end

  assign cand      = lock ? owner_mask : req_valid;
  assign ptr_after = IDX_W'(rr_next(int'(grant_idx), NUM_REQ));

  uart_rr_pick #(.N(NUM_REQ), .IW(IDX_W)) u_pick (
    .req   (cand),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

`ifdef UART_TX_ARB_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TO_W-1:0] to_cnt;
  logic            counting;

  assign counting = ((state == ARB_SEND) & ~send.completed)
                  | ((state == ARB_IDLE) & lock & ~pick_found);
  assign to_fire  = counting & (to_cnt == TO_W'(TIMEOUT_CYC - 1));

  // Watchdog: any state change drops counting for a cycle, which clears the count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt      <= '0;
      timeout_err <= 1'b0;
    end else begin
      timeout_err <= to_fire;
      to_cnt      <= (counting & ~to_fire) ? to_cnt + TO_W'(1) : '0;
    end
  end
`else
  assign to_fire = 1'b0;
`endif

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ARB_IDLE;
      rr_ptr    <= '0;
      lock      <= 1'b0;
      grant_idx <= '0;
      req_ready <= '0;
      send.en   <= 1'b0;
      send.data <= 8'h00;
      busy      <= 1'b0;
    end else begin
      req_ready <= '0;
      if (to_fire) begin
        send.en <= 1'b0;
        lock    <= 1'b0;
        rr_ptr  <= ptr_after;
        state   <= ARB_GAP;
        busy    <= 1'b1;
      end else begin
        case (state)
          ARB_IDLE: begin
            if (pick_found) begin
              grant_idx <= pick_idx;
              send.data <= req_data[{pick_idx, 3'b000} +: 8];
              lock      <= ~req_last[pick_idx];
              req_ready <= pick_onehot;
              send.en   <= 1'b1;
              busy      <= 1'b1;
              state     <= ARB_SEND;
            end else begin
              busy <= lock;
            end
          end
          ARB_SEND: begin
            if (send.completed) begin
              send.en <= 1'b0;
              state   <= ARB_GAP;
              // lock is already clear when the byte just sent closed its packet
              rr_ptr  <= lock ? rr_ptr : ptr_after;
            end else begin
              send.en <= 1'b1;
            end
          end
          ARB_GAP: begin
            state <= ARB_IDLE;
            busy  <= lock;
          end
          default: begin
            state   <= ARB_IDLE;
            send.en <= 1'b0;
            busy    <= lock;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb with a behavioural uart_comm byte sink and scoreboard.
module tb_uart_tx_arb;
  import uart_arb_pkg::*;

  localparam int BYTE_CYC = 12;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  rv = 4'h0;
  logic [31:0] rd = 32'h0;
  logic [3:0]  rl = 4'h0;
  logic [3:0]  rr;
  logic [1:0]  gi;
  logic        bz;
`ifdef UART_TX_ARB_TIMEOUT_EN
  logic        to_err;
`endif

  uart_send_inf send_if();

  uart_tx_arb #(
    .NUM_REQ(4)
`ifdef UART_TX_ARB_TIMEOUT_EN
    , .TIMEOUT_CYC(2000)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (rv),
    .req_data  (rd),
    .req_last  (rl),
    .req_ready (rr),
    .send      (send_if.sender),
    .grant_idx (gi),
`ifdef UART_TX_ARB_TIMEOUT_EN
    .timeout_err (to_err),
`endif
    .busy      (bz)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int failed = 0;
  int onehot_err = 0;
  int stab_err = 0;
  int bcnt = 0;
  logic [7:0] byte_start;
  logic [9:0] exp_q [$];
  logic [9:0] got_q [$];
  logic [8:0] src [4][8];
  int head [4];
  int tail [4];

  // uart_comm stand-in: holds each byte BYTE_CYC cycles, then pulses completed.
  always @(negedge clk or negedge rst) begin
    if (!rst) begin
      bcnt <= 0;
      send_if.completed <= 1'b0;
    end else if (send_if.completed) begin
      send_if.completed <= 1'b0;
      bcnt <= 0;
    end else if (send_if.en) begin
      if (bcnt == 0) byte_start <= send_if.data;
      else if (send_if.data != byte_start) stab_err <= stab_err + 1;
      if (bcnt == BYTE_CYC) begin
        send_if.completed <= 1'b1;
        got_q.push_back({gi, send_if.data});
      end
      bcnt <= bcnt + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic present();
    for (int i = 0; i < 4; i++) begin
      if (head[i] < tail[i]) begin
        rv[i]        = 1'b1;
        rd[8*i +: 8] = src[i][head[i]][7:0];
        rl[i]        = src[i][head[i]][8];
      end else begin
        rv[i] = 1'b0;
      end
    end
  endtask

  task automatic enq(input int i, input logic [7:0] d, input logic l);
    if (head[i] == tail[i]) begin
      head[i] = 0;
      tail[i] = 0;
    end
    src[i][tail[i]] = {l, d};
    tail[i]++;
  endtask

  task automatic expect_byte(input logic [1:0] idx, input logic [7:0] d);
    exp_q.push_back({idx, d});
  endtask

  task automatic step();
    logic [9:0] g;
    logic [9:0] e;
    @(negedge clk);
    #1;
    if ($countones(rr) > 1) onehot_err++;
    while (got_q.size() > 0) begin
      g = got_q.pop_front();
      if (exp_q.size() == 0) begin
        check("sb_unexpected_byte", {22'd0, g}, 32'h0);
      end else begin
        e = exp_q.pop_front();
        check("sb_idx_byte", {22'd0, g}, {22'd0, e});
      end
    end
    for (int i = 0; i < 4; i++) if (rr[i]) head[i]++;
    present();
  endtask

  task automatic run(input string name, input int budget);
    int  k;
    logic done;
    k = 0;
    done = 1'b0;
    while (!done && k < budget) begin
      step();
      k++;
      done = (rv == 4'h0) && (exp_q.size() == 0) && !bz && !send_if.en;
    end
    check({name, "_drained"}, {31'd0, done}, 32'd1);
  endtask

  typedef struct packed {
    logic [3:0] mask;
    logic [7:0] base;
    logic [2:0] n;
    logic [7:0] ord;
  } vec_t;

  vec_t tbl [7];

  initial begin
    int   k;
    logic stall_bad;
    logic [1:0] o;
    for (int i = 0; i < 4; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    // mask, base byte (requester i sends base+i), count, grant order {o3,o2,o1,o0}
    tbl[0] = '{4'b1000, 8'h0F, 3'd1, {2'd0, 2'd0, 2'd0, 2'd3}};
    tbl[1] = '{4'b1111, 8'h10, 3'd4, {2'd3, 2'd2, 2'd1, 2'd0}};
    tbl[2] = '{4'b1111, 8'h20, 3'd4, {2'd3, 2'd2, 2'd1, 2'd0}};
    tbl[3] = '{4'b1001, 8'h30, 3'd2, {2'd0, 2'd0, 2'd3, 2'd0}};
    tbl[4] = '{4'b0110, 8'h40, 3'd2, {2'd0, 2'd0, 2'd2, 2'd1}};
    tbl[5] = '{4'b0101, 8'h50, 3'd2, {2'd0, 2'd0, 2'd2, 2'd0}};
    tbl[6] = '{4'b1010, 8'h60, 3'd2, {2'd0, 2'd0, 2'd1, 2'd3}};

    #2 rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_en", {31'd0, send_if.en}, 32'd0);
    check("rst_data", {24'd0, send_if.data}, 32'd0);
    check("rst_ready", {28'd0, rr}, 32'd0);
    check("rst_grant", {30'd0, gi}, 32'd0);
    check("rst_busy", {31'd0, bz}, 32'd0);
    rst = 1'b1;
    step();

    // Single requester, one-cycle ready latency and end-of-byte sequencing.
    enq(0, 8'hA5, 1'b1);
    expect_byte(2'd0, 8'hA5);
    present();
    check("a5_ready_before", {28'd0, rr}, 32'd0);
    step();
    check("a5_ready", {28'd0, rr}, 32'h1);
    check("a5_en", {31'd0, send_if.en}, 32'd1);
    check("a5_data", {24'd0, send_if.data}, 32'hA5);
    check("a5_grant", {30'd0, gi}, 32'd0);
    check("a5_busy", {31'd0, bz}, 32'd1);
    k = 0;
    while (!send_if.completed && k < 100) begin
      step();
      k++;
    end
    check("a5_completed_seen", {31'd0, send_if.completed}, 32'd1);
    step();
    check("a5_en_drop", {31'd0, send_if.en}, 32'd0);
    check("a5_gap_busy", {31'd0, bz}, 32'd1);
    check("a5_rr_ptr", {30'd0, dut.rr_ptr}, 32'd1);
    step();
    check("a5_idle_busy", {31'd0, bz}, 32'd0);
    run("a5", 50);

    // Table-driven round-robin rounds.
    for (int t = 0; t < 7; t++) begin
      for (int i = 0; i < 4; i++)
        if (tbl[t].mask[i]) enq(i, tbl[t].base + 8'(i), 1'b1);
      for (int j = 0; j < int'(tbl[t].n); j++) begin
        o = tbl[t].ord[2*j +: 2];
        expect_byte(o, tbl[t].base + {6'd0, o});
      end
      present();
      run($sformatf("vec%0d", t), 2000);
    end

    // Packet lock: req 2 keeps the transmitter for all three bytes before req 1.
    enq(2, 8'hC0, 1'b0);
    enq(2, 8'hC1, 1'b0);
    enq(2, 8'hC2, 1'b1);
    enq(1, 8'hD1, 1'b1);
    expect_byte(2'd2, 8'hC0);
    expect_byte(2'd2, 8'hC1);
    expect_byte(2'd2, 8'hC2);
    expect_byte(2'd1, 8'hD1);
    present();
    run("lock", 2000);

    // Lock stall: owner 3 goes silent mid-packet while req 0 waits.
    enq(3, 8'h77, 1'b0);
    expect_byte(2'd3, 8'h77);
    present();
    k = 0;
    while (exp_q.size() > 0 && k < 200) begin
      step();
      k++;
    end
    check("stall_first_byte", exp_q.size(), 32'd0);
    enq(0, 8'h88, 1'b1);
    present();
    stall_bad = 1'b0;
`ifdef UART_TX_ARB_TIMEOUT_EN
    begin
      logic saw_to;
      saw_to = 1'b0;
      expect_byte(2'd0, 8'h88);
      for (int c = 0; c < 5000; c++) begin
        if (!saw_to && (rr[0] || !bz)) stall_bad = 1'b1;
        step();
        if (to_err) saw_to = 1'b1;
      end
      check("stall_hold", {31'd0, stall_bad}, 32'd0);
      check("timeout_pulse", {31'd0, saw_to}, 32'd1);
      run("timeout_serve", 500);
      enq(3, 8'h78, 1'b1);
      expect_byte(2'd3, 8'h78);
      present();
      run("stall_release", 500);
    end
`else
    for (int c = 0; c < 5000; c++) begin
      step();
      if (rr[0] || !bz) stall_bad = 1'b1;
    end
    check("stall_hold", {31'd0, stall_bad}, 32'd0);
    enq(3, 8'h78, 1'b1);
    expect_byte(2'd3, 8'h78);
    expect_byte(2'd0, 8'h88);
    present();
    run("stall_release", 500);
`endif

    // Move the pointer to 3 so a post-reset pick from 0 is distinguishable.
    enq(2, 8'h9A, 1'b1);
    expect_byte(2'd2, 8'h9A);
    present();
    run("pre_reset", 500);

    // Reset in the middle of a byte.
    enq(0, 8'h3C, 1'b1);
    present();
    k = 0;
    while (!send_if.en && k < 20) begin
      step();
      k++;
    end
    for (int c = 0; c < 5; c++) step();
    check("midbyte_en", {31'd0, send_if.en}, 32'd1);
    #2 rst = 1'b0;
    #1;
    check("async_en", {31'd0, send_if.en}, 32'd0);
    check("async_data", {24'd0, send_if.data}, 32'd0);
    check("async_grant", {30'd0, gi}, 32'd0);
    check("async_busy", {31'd0, bz}, 32'd0);
    check("async_rr_ptr", {30'd0, dut.rr_ptr}, 32'd0);
    check("async_lock", {31'd0, dut.lock}, 32'd0);
    check("async_state", {30'd0, dut.state}, {30'd0, ARB_IDLE});
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 4; i++) head[i] = tail[i];
    present();
    @(negedge clk);
    #1 rst = 1'b1;
    enq(1, 8'h5A, 1'b1);
    enq(3, 8'h5B, 1'b1);
    expect_byte(2'd1, 8'h5A);
    expect_byte(2'd3, 8'h5B);
    present();
    run("post_reset", 500);

    // Data stability: requester changes its byte right after acceptance.
    enq(0, 8'hE7, 1'b1);
    expect_byte(2'd0, 8'hE7);
    present();
    k = 0;
    while (!rr[0] && k < 20) begin
      step();
      k++;
    end
    rd[7:0] = 8'h18;
    check("stable_data_latched", {24'd0, send_if.data}, 32'hE7);
    run("stable", 500);

    check("onehot_ready", onehot_err, 32'd0);
    check("data_stable", stab_err, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
